cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
//
// PURPOSE
//   Synthesizable, parametrised CPU trace recorder for the 68k-based arcade core.
//   Captures qualified instruction-fetch samples {fc, pc, data} into a circular
//   on-chip RAM, with PC-match or external trigger, post-trigger count and
//   oldest-first readout, so a trace is available on hardware, not only in sim.
//   Sits beside the CPU in the s_6mhz domain; readout goes to a debug/LED port.
//
// PARAMETERS
//   ADDR_W      24   pc width (68k address bus)
//   DATA_W      32   side-data width (register snapshot, e.g. d0/a0)
//   DEPTH_LOG2  8    log2 of trace depth; DEPTH = 2**DEPTH_LOG2 entries
//
// PORTS
//   clk         in   1            single clock (CPU clock enable domain)
//   reset       in   1            synchronous, active-high
//   sample_en   in   1            CPU presents a fetch/exec sample this cycle
//   fc          in   3            function code of the sample
//   pc          in   ADDR_W       program counter of the sample
//   data        in   DATA_W       side data captured with the sample
//   fc_mask     in   8            bit[fc]=1 accepts samples with that fc
//   mode        in   2            0 free-run, 1 trigger+post, 2 one-shot fill, 3 = 0
//   arm         in   1            pulse: clear buffer and start capture
//   stop        in   1            pulse: halt capture, keep contents
//   trig_en     in   1            enable pc==trig_pc trigger
//   trig_pc     in   ADDR_W       trigger address
//   ext_trig    in   1            external trigger (level, sampled while ARMED)
//   post_len    in   DEPTH_LOG2   samples stored after the trigger sample
//   rd_req      in   1            read request
//   rd_idx      in   DEPTH_LOG2   entry index, 0 = oldest stored
//   rd_valid    out  1            pulse, 1 cycle after rd_req
//   rd_data     out  3+ADDR_W+DATA_W  {fc, pc, data} of requested entry
//   state       out  2            0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count       out  DEPTH_LOG2+1 stored entries, saturates at DEPTH
//   triggered   out  1            trigger has occurred since arm
//   trig_idx    out  DEPTH_LOG2   rd_idx of trigger sample, valid at DONE
//
// BEHAVIOUR
//   - Reset: state=IDLE, wr_ptr=0, count=0, triggered=0, trig_idx=0,
//     rd_valid=0, rd_data=0. RAM contents undefined.
//   - Accept = sample_en & fc_mask[fc] & state in {ARMED, POST}.
//     Accepted: mem[wr_ptr] <= {fc,pc,data}; wr_ptr++ mod DEPTH;
//     count = min(count+1, DEPTH).
//   - Priority each cycle: reset > arm > stop > sample/trigger.
//     arm: wr_ptr=0, count=0, triggered=0, state=ARMED next cycle.
//     A sample in the arm cycle is dropped.
//     stop: state=IDLE, contents/count kept. A sample in the stop cycle is dropped.
//   - ARMED, mode 0: wraps forever, never triggers.
//   - ARMED, mode 2: DONE on the accept that makes count==DEPTH; no wrap.
//   - ARMED, mode 1: trigger = accept & ((trig_en & pc==trig_pc) | ext_trig).
//     Trigger sample is stored; triggered=1; trig_idx records its position.
//     post_len==0 -> DONE; else POST with rem=post_len.
//   - POST: each accept stores and decrements rem; the accept making rem==0
//     -> DONE. Further triggers are ignored.
//   - DONE/IDLE: samples ignored, readout allowed.
//   - Readout: phys = (count==DEPTH ? wr_ptr : 0) + rd_idx mod DEPTH.
//     rd_data registered, 1-cycle latency with rd_valid.
//     rd_idx >= count -> rd_data=0, rd_valid still pulses.
//     Read concurrent with a write to the same slot returns old data.
//   - trig_idx = (trig_phys - oldest_phys) mod DEPTH, recomputed as the
//     buffer wraps.
//
// TESTING (DEPTH_LOG2=4 unless noted)
//   1. reset, arm, mode 0, 20 accepts pc=0x100..0x113
//      -> count=16; rd_idx 0 = 0x104; rd_idx 15 = 0x113.
//   2. mode 2, 20 accepts -> DONE after 16th; rd_idx 15 = 0x10F;
//      samples 17-20 not stored.
//   3. mode 1, trig_pc=0x108, post_len=3, pc=0x100.. -> DONE after 0x10B;
//      count=12; trig_idx=8; triggered=1.
//   4. fc_mask=8'h40, samples alternate fc=6/fc=5
//      -> only fc=6 stored; count = half the sample count.
//   5. arm and sample_en asserted in the same cycle -> sample dropped, state=ARMED.
//      stop during POST -> IDLE, contents readable.
//   6. Reset mid-POST -> all outputs at reset values next cycle.
//      rd_req with rd_idx=count -> rd_valid=1, rd_data=0.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Circular CPU instruction-trace recorder: captures {fc, pc, data} samples with
// PC/external trigger, post-trigger count and oldest-first indexed readout.
module cpu_trace_buffer #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_en,
    input  logic [2:0]                   fc,
    input  logic [ADDR_W-1:0]            pc,
    input  logic [DATA_W-1:0]            data,
    input  logic [7:0]                   fc_mask,
    input  logic [1:0]                   mode,
    input  logic                         arm,
    input  logic                         stop,
    input  logic                         trig_en,
    input  logic [ADDR_W-1:0]            trig_pc,
    input  logic                         ext_trig,
    input  logic [DEPTH_LOG2-1:0]        post_len,
    input  logic                         rd_req,
    input  logic [DEPTH_LOG2-1:0]        rd_idx,
    output logic                         rd_valid,
    output logic [3+ADDR_W+DATA_W-1:0]   rd_data,
    output logic [1:0]                   state,
    output logic [DEPTH_LOG2:0]          count,
    output logic                         triggered,
    output logic [DEPTH_LOG2-1:0]        trig_idx
);

    localparam int ENTRY_W = 3 + ADDR_W + DATA_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   C_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] C_PTR_0   = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] C_PTR_1   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [ENTRY_W-1:0]    C_ENT_0   = {ENTRY_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
    logic                  r_triggered, w_triggered_nxt;
    logic [DEPTH_LOG2-1:0] r_trig_phys, w_trig_phys_nxt;
    logic [DEPTH_LOG2-1:0] r_trig_idx, w_trig_idx_nxt;
    logic [DEPTH_LOG2-1:0] r_rem, w_rem_nxt;
    logic                  r_rd_valid;
    logic [ENTRY_W-1:0]    r_rd_data;
    logic [ENTRY_W-1:0]    r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_trig_hit;
    logic [DEPTH_LOG2-1:0] w_oldest;
    logic [DEPTH_LOG2-1:0] w_rd_phys;
    logic                  w_rd_in_range;

    // arm and stop both swallow any sample presented in the same cycle
    assign w_accept      = sample_en & fc_mask[fc] & ~arm & ~stop &
                           ((r_state == S_ARMED) | (r_state == S_POST));
    assign w_trig_hit    = (trig_en & (pc == trig_pc)) | ext_trig;
    assign w_oldest      = (r_count == C_DEPTH) ? r_wr_ptr : C_PTR_0;
    assign w_rd_phys     = w_oldest + rd_idx;
    assign w_rd_in_range = ({1'b0, rd_idx} < r_count);

    // Next-state, pointer, count and trigger bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_triggered_nxt = r_triggered;
        w_trig_phys_nxt = r_trig_phys;
        w_rem_nxt       = r_rem;
        if (arm) begin
            w_state_nxt     = S_ARMED;
            w_wr_ptr_nxt    = C_PTR_0;
            w_count_nxt     = {(DEPTH_LOG2+1){1'b0}};
            w_triggered_nxt = 1'b0;
            w_trig_phys_nxt = C_PTR_0;
            w_rem_nxt       = C_PTR_0;
        end else if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_wr_ptr_nxt = r_wr_ptr + C_PTR_1;
            w_count_nxt  = (r_count == C_DEPTH) ? r_count : r_count + C_CNT_ONE;
            case (r_state)
                S_ARMED: begin
                    case (mode)
                        2'd1: begin
                            if (w_trig_hit) begin
                                w_triggered_nxt = 1'b1;
                                w_trig_phys_nxt = r_wr_ptr;
                                w_rem_nxt       = post_len;
                                w_state_nxt     = (post_len == C_PTR_0) ? S_DONE : S_POST;
                            end else begin
                                w_state_nxt = S_ARMED;
                            end
                        end
                        2'd2: begin
                            if (r_count + C_CNT_ONE == C_DEPTH) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_ARMED;
                            end
                        end
                        default: w_state_nxt = S_ARMED;
                    endcase
                end
                S_POST: begin
                    w_rem_nxt   = r_rem - C_PTR_1;
                    w_state_nxt = (r_rem == C_PTR_1) ? S_DONE : S_POST;
                end
                default: w_state_nxt = r_state;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
        // trigger position is kept relative to whatever is oldest after this cycle
        w_trig_idx_nxt = w_trig_phys_nxt -
                         ((w_count_nxt == C_DEPTH) ? w_wr_ptr_nxt : C_PTR_0);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= C_PTR_0;
            r_count     <= {(DEPTH_LOG2+1){1'b0}};
            r_triggered <= 1'b0;
            r_trig_phys <= C_PTR_0;
            r_trig_idx  <= C_PTR_0;
            r_rem       <= C_PTR_0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_triggered <= w_triggered_nxt;
            r_trig_phys <= w_trig_phys_nxt;
            r_trig_idx  <= w_trig_idx_nxt;
            r_rem       <= w_rem_nxt;
        end
    end

    // Trace RAM write port
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {fc, pc, data};
        end
    end

    // Registered readout; out-of-range indices return zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= C_ENT_0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_in_range ? r_mem[w_rd_phys] : C_ENT_0;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign state     = r_state;
    assign count     = r_count;
    assign triggered = r_triggered;
    assign trig_idx  = r_trig_idx;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer at DEPTH_LOG2=4: a queue-based model of
// the stored trace predicts readout, pushed on rd_req and popped on rd_valid.
module tb_cpu_trace_buffer;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int DL = 4;
    localparam int DEPTH = 16;
    localparam int EW = 3 + AW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_en = 1'b0;
    logic [2:0]    fc = 3'd0;
    logic [AW-1:0] pc = 24'd0;
    logic [DW-1:0] data = 32'd0;
    logic [7:0]    fc_mask = 8'hFF;
    logic [1:0]    mode = 2'd0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          trig_en = 1'b0;
    logic [AW-1:0] trig_pc = 24'd0;
    logic          ext_trig = 1'b0;
    logic [DL-1:0] post_len = 4'd0;
    logic          rd_req = 1'b0;
    logic [DL-1:0] rd_idx = 4'd0;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [1:0]    state;
    logic [DL:0]   count;
    logic          triggered;
    logic [DL-1:0] trig_idx;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] m_store [$];
    logic [EW-1:0] exp_q [$];
    int m_state = 0;
    int m_total = 0;
    int m_trig_abs = 0;
    int m_rem = 0;
    bit m_trig = 1'b0;

    cpu_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .fc(fc), .pc(pc),
        .data(data), .fc_mask(fc_mask), .mode(mode), .arm(arm), .stop(stop),
        .trig_en(trig_en), .trig_pc(trig_pc), .ext_trig(ext_trig),
        .post_len(post_len), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data), .state(state), .count(count),
        .triggered(triggered), .trig_idx(trig_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rd_valid pulse must match the oldest pending read
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rd_unexpected", 64'd1, 64'd0);
            end else begin
                check_eq("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_clear();
        m_store.delete();
        m_total = 0;
        m_trig = 1'b0;
        m_trig_abs = 0;
        m_rem = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        m_state = 0;
    endtask

    task automatic do_arm(input bit with_sample);
        arm = 1'b1;
        sample_en = with_sample;
        fc = 3'd6; pc = 24'hABC; data = 32'h1234;
        @(posedge clk); #1;
        arm = 1'b0; sample_en = 1'b0;
        model_clear();
        m_state = 1;
    endtask

    task automatic do_stop(input bit with_sample);
        stop = 1'b1;
        sample_en = with_sample;
        fc = 3'd6; pc = 24'hDEF; data = 32'h5678;
        @(posedge clk); #1;
        stop = 1'b0; sample_en = 1'b0;
        m_state = 0;
    endtask

    task automatic send(input logic [2:0] f, input logic [AW-1:0] p);
        logic [DW-1:0] d;
        d = {8'hA5, p};
        sample_en = 1'b1; fc = f; pc = p; data = d;
        if ((m_state == 1 || m_state == 2) && fc_mask[f]) begin
            m_store.push_back({f, p, d});
            if (m_store.size() > DEPTH) void'(m_store.pop_front());
            m_total++;
            if (m_state == 1) begin
                if (mode == 2'd1 && ((trig_en && p == trig_pc) || ext_trig)) begin
                    m_trig = 1'b1;
                    m_trig_abs = m_total - 1;
                    m_rem = int'(post_len);
                    m_state = (post_len == 4'd0) ? 3 : 2;
                end else if (mode == 2'd2 && m_total == DEPTH) begin
                    m_state = 3;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic read(input int idx);
        rd_req = 1'b1;
        rd_idx = DL'(idx);
        exp_q.push_back((idx < m_store.size()) ? m_store[idx] : {EW{1'b0}});
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_state"}, 64'(state), 64'(m_state));
        check_eq({tag, "_count"}, 64'(count), 64'(m_store.size()));
        check_eq({tag, "_triggered"}, 64'(triggered), 64'(m_trig));
        if (m_trig)
            check_eq({tag, "_trig_idx"}, 64'(trig_idx),
                     64'(m_trig_abs - (m_total - m_store.size())));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_trig", 64'(triggered), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);

        // 1: free-run wraps, count saturates
        mode = 2'd0; fc_mask = 8'hFF;
        do_arm(1'b0);
        for (int i = 0; i < 20; i++) send(3'd6, 24'h100 + AW'(i));
        check_status("t1");
        read(0); read(15); read(7);

        // 2: one-shot fill stops at DEPTH
        mode = 2'd2;
        do_arm(1'b0);
        for (int i = 0; i < 20; i++) send(3'd6, 24'h100 + AW'(i));
        check_status("t2");
        read(15); read(0);

        // 3: pc trigger with post count, then a trigger after wrap
        mode = 2'd1; trig_en = 1'b1; trig_pc = 24'h108; post_len = 4'd3;
        do_arm(1'b0);
        for (int i = 0; i < 16; i++) send(3'd6, 24'h100 + AW'(i));
        check_status("t3");
        read(8); read(11); read(12);
        trig_pc = 24'h112; post_len = 4'd2;
        do_arm(1'b0);
        for (int i = 0; i < 24; i++) send(3'd6, 24'h100 + AW'(i));
        check_status("t3w");
        read(0); read(12); read(15);

        // 4: fc mask filters alternate samples
        mode = 2'd0; trig_en = 1'b0; fc_mask = 8'h40;
        do_arm(1'b0);
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 3'd6 : 3'd5, 24'h400 + AW'(i));
        check_status("t4");
        for (int i = 0; i < 6; i++) read(i);
        fc_mask = 8'hFF;

        // 5: sample dropped in arm cycle; stop during POST keeps contents
        mode = 2'd1; post_len = 4'd5;
        do_arm(1'b0);
        for (int i = 0; i < 3; i++) send(3'd6, 24'h500 + AW'(i));
        do_arm(1'b1);
        check_status("t5arm");
        send(3'd6, 24'h200); send(3'd6, 24'h201);
        ext_trig = 1'b1; send(3'd6, 24'h202); ext_trig = 1'b0;
        send(3'd6, 24'h203); send(3'd6, 24'h204);
        check_status("t5post");
        do_stop(1'b1);
        check_status("t5stop");
        send(3'd6, 24'h300);
        check_status("t5idle");
        for (int i = 0; i < 6; i++) read(i);

        // 6: reset mid-POST, then out-of-range reads
        trig_en = 1'b1; trig_pc = 24'h108; post_len = 4'd5;
        do_arm(1'b0);
        for (int i = 0; i < 10; i++) send(3'd6, 24'h100 + AW'(i));
        check_status("t6pre");
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_status("t6rst");
        check_eq("t6rst_trig_idx", 64'(trig_idx), 64'd0);
        check_eq("t6rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("t6rst_rd_data", 64'(rd_data), 64'd0);
        read(0);
        mode = 2'd0;
        do_arm(1'b0);
        for (int i = 0; i < 3; i++) send(3'd6, 24'h600 + AW'(i));
        read(3); read(2);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
